// File: rtl/subleq_loader.sv
// Boot loader that streams a SUBLEQ program image into RAM, then releases the CPU.
// Optional LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte check.
module subleq_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter logic [7:0] LAST_ADDR = 8'hFF
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ld_start,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    output logic       ram_we,
    output logic [7:0] ram_adr,
    output logic [7:0] ram_dat,
    output logic       cpu_run,
    output logic       done,
    output logic       err,
    output logic [7:0] count
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHK, S_RUN, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_ERR
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       we_q, we_d;
    logic [7:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d;
    logic       accept;
    logic       load_acc;
    logic       fresh;

    assign accept   = ld_valid && ld_ready;
    assign load_acc = accept && (state_q == S_LOAD);
    assign fresh    = ld_start && ((state_q == S_IDLE) || (state_q == S_ERR));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (ld_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (accept) begin
                    if (ld_last) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_RUN;
`endif
                    end else if (ptr_q == LAST_ADDR) begin
                        state_d = S_ERR;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d = (ld_data == sum_q) ? S_RUN : S_ERR;
                end
            end
`endif
            S_RUN: state_d = S_RUN;
            S_ERR: begin
                if (ld_start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The CPU stays held while the final image byte is still being written.
    always_comb begin
`ifdef LOADER_CHECKSUM_EN
        ld_ready = (state_q == S_LOAD) || (state_q == S_CHK);
`else
        ld_ready = (state_q == S_LOAD);
`endif
        cpu_run = (state_q == S_RUN) && !we_q;
        done    = (state_q == S_RUN) && !we_q;
        err     = (state_q == S_ERR);
    end

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        we_d  = 1'b0;
        adr_d = adr_q;
        dat_d = dat_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d = sum_q;
`endif
        if (fresh) begin
            ptr_d = BASE_ADDR;
            cnt_d = 8'h00;
`ifdef LOADER_CHECKSUM_EN
            sum_d = 8'h00;
`endif
        end else if (load_acc) begin
            we_d  = 1'b1;
            adr_d = ptr_q;
            dat_d = ld_data;
            ptr_d = ptr_q + 8'h01;
            cnt_d = cnt_q + 8'h01;
`ifdef LOADER_CHECKSUM_EN
            sum_d = sum_q + ld_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            ptr_q <= BASE_ADDR;
            cnt_q <= 8'h00;
            we_q  <= 1'b0;
            adr_q <= BASE_ADDR;
            dat_q <= 8'h00;
`ifdef LOADER_CHECKSUM_EN
            sum_q <= 8'h00;
`endif
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            we_q  <= we_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q <= sum_d;
`endif
        end
    end

    assign ram_we  = we_q;
    assign ram_adr = adr_q;
    assign ram_dat = dat_q;
    assign count   = cnt_q;

endmodule

// File: tb/tb_subleq_loader.sv
// Bench for subleq_loader: two instances (default and FD..FF window)
// checked every cycle against a behavioural model, plus directed literals.
module tb_subleq_loader;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       ld_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = 8'h00;
    logic       ld_last = 1'b0;

    logic       ready_a, we_a, run_a, done_a, err_a;
    logic [7:0] adr_a, dat_a, cnt_a;
    logic       ready_b, we_b, run_b, done_b, err_b;
    logic [7:0] adr_b, dat_b, cnt_b;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;

    logic [7:0] wlog_a[$];
    logic [7:0] wlog_b[$];

    // model state: 0 idle, 1 load, 2 chk, 3 run, 4 err
    int         m_mode[2];
    logic [7:0] m_ptr[2];
    logic [7:0] m_cnt[2];
    logic [7:0] m_adr[2];
    logic [7:0] m_dat[2];
    logic [7:0] m_sum[2];
    logic       m_we[2];

    always #5 clk = ~clk;

    subleq_loader u_a (
        .clk(clk), .res(res), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ready_a),
        .ram_we(we_a), .ram_adr(adr_a), .ram_dat(dat_a),
        .cpu_run(run_a), .done(done_a), .err(err_a), .count(cnt_a)
    );

    subleq_loader #(.BASE_ADDR(8'hFD), .LAST_ADDR(8'hFF)) u_b (
        .clk(clk), .res(res), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ready_b),
        .ram_we(we_b), .ram_adr(adr_b), .ram_dat(dat_b),
        .cpu_run(run_b), .done(done_b), .err(err_b), .count(cnt_b)
    );

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mstep(input int i, input logic [7:0] base,
                         input logic [7:0] lim);
        logic acc;
        m_we[i] = 1'b0;
        acc = ld_valid && (m_mode[i] == 1 || m_mode[i] == 2);
        if (res) begin
            m_mode[i] = 0;
            m_ptr[i] = base;
            m_cnt[i] = 8'h00;
            m_adr[i] = base;
            m_dat[i] = 8'h00;
            m_sum[i] = 8'h00;
        end else if ((m_mode[i] == 0 || m_mode[i] == 4) && ld_start) begin
            m_mode[i] = 1;
            m_ptr[i] = base;
            m_cnt[i] = 8'h00;
            m_sum[i] = 8'h00;
        end else if (m_mode[i] == 1 && acc) begin
            m_we[i] = 1'b1;
            m_adr[i] = m_ptr[i];
            m_dat[i] = ld_data;
            m_sum[i] = m_sum[i] + ld_data;
            m_cnt[i] = m_cnt[i] + 8'h01;
            if (ld_last) begin
`ifdef LOADER_CHECKSUM_EN
                m_mode[i] = 2;
`else
                m_mode[i] = 3;
`endif
            end else if (m_ptr[i] == lim) begin
                m_mode[i] = 4;
            end
            m_ptr[i] = m_ptr[i] + 8'h01;
        end else if (m_mode[i] == 2 && acc) begin
            m_mode[i] = (ld_data == m_sum[i]) ? 3 : 4;
        end
    endtask

    always @(posedge clk) begin
        mstep(0, 8'h00, 8'hFF);
        mstep(1, 8'hFD, 8'hFF);
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("a.ready", 8'(ready_a), 8'(m_mode[0] == 1 || m_mode[0] == 2));
            chk("a.we", 8'(we_a), 8'(m_we[0]));
            chk("a.adr", adr_a, m_adr[0]);
            chk("a.dat", dat_a, m_dat[0]);
            chk("a.run", 8'(run_a), 8'(m_mode[0] == 3 && !m_we[0]));
            chk("a.done", 8'(done_a), 8'(m_mode[0] == 3 && !m_we[0]));
            chk("a.err", 8'(err_a), 8'(m_mode[0] == 4));
            chk("a.count", cnt_a, m_cnt[0]);
            chk("b.ready", 8'(ready_b), 8'(m_mode[1] == 1 || m_mode[1] == 2));
            chk("b.we", 8'(we_b), 8'(m_we[1]));
            chk("b.adr", adr_b, m_adr[1]);
            chk("b.dat", dat_b, m_dat[1]);
            chk("b.run", 8'(run_b), 8'(m_mode[1] == 3 && !m_we[1]));
            chk("b.err", 8'(err_b), 8'(m_mode[1] == 4));
            chk("b.count", cnt_b, m_cnt[1]);
            chk("b.window", 8'(we_b && adr_b < 8'hFD), 8'h00);
            chk("a.run_we", 8'(run_a && we_a), 8'h00);
        end
        if (we_a) wlog_a.push_back(adr_a);
        if (we_b) wlog_b.push_back(adr_b);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        res = 1'b1;
        tick();
        res = 1'b0;
        wlog_a.delete();
        wlog_b.delete();
    endtask

    task automatic start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        ld_valid = 1'b1;
        ld_data = d;
        ld_last = l;
        tick();
        ld_valid = 1'b0;
        ld_last = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        armed = 1'b1;
        chk("rst.ready", 8'(ready_a), 8'h00);
        chk("rst.we", 8'(we_a), 8'h00);
        chk("rst.adr_a", adr_a, 8'h00);
        chk("rst.adr_b", adr_b, 8'hFD);
        chk("rst.dat", dat_a, 8'h00);
        chk("rst.count", cnt_a, 8'h00);
        chk("rst.run", 8'(run_a), 8'h00);
        chk("rst.err", 8'(err_a), 8'h00);
        res = 1'b0;
        wlog_a.delete();
        wlog_b.delete();

        // three-byte image
        start();
        send(8'h05, 1'b0);
        chk("img.adr0", adr_a, 8'h00);
        chk("img.dat0", dat_a, 8'h05);
        send(8'h06, 1'b0);
        send(8'h00, 1'b1);
        chk("img.dat2", dat_a, 8'h00);
        chk("img.adr2", adr_a, 8'h02);
        chk("img.run_hold", 8'(run_a), 8'h00);
        tick();
        chk("img.run", 8'(run_a), 8'h01);
        chk("img.count", cnt_a, 8'h03);
        chk("img.b_run", 8'(run_b), 8'h01);
        start();
        chk("img.start_ignored", 8'(run_a), 8'h01);

        // overflow on the FD..FF instance
        do_reset();
        start();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b1);
        tick();
        chk("ovf.err", 8'(err_b), 8'h01);
        chk("ovf.run", 8'(run_b), 8'h00);
        chk("ovf.count", cnt_b, 8'h03);
        chk("ovf.nwr", 8'(wlog_b.size()), 8'h03);
        if (wlog_b.size() == 3) begin
            chk("ovf.w0", wlog_b[0], 8'hFD);
            chk("ovf.w2", wlog_b[2], 8'hFF);
        end
        chk("ovf.a_run", 8'(run_a), 8'h01);
        start();
        chk("ovf.restart_err", 8'(err_b), 8'h00);
        chk("ovf.restart_cnt", cnt_b, 8'h00);
        send(8'h77, 1'b0);
        chk("ovf.restart_adr", adr_b, 8'hFD);

        // reset during the second accept
        do_reset();
        start();
        send(8'h11, 1'b0);
        ld_valid = 1'b1;
        ld_data = 8'h22;
        res = 1'b1;
        tick();
        res = 1'b0;
        ld_valid = 1'b0;
        chk("abort.we", 8'(we_a), 8'h00);
        chk("abort.count", cnt_a, 8'h00);
        chk("abort.run", 8'(run_a), 8'h00);
        chk("abort.ready", 8'(ready_a), 8'h00);

        // gapped valid
        do_reset();
        start();
        for (int k = 0; k < 6; k++) begin
            send(8'h40 + 8'(k), k == 5);
            tick();
            tick();
        end
        chk("gap.nwr", 8'(wlog_a.size()), 8'h06);
        for (int k = 0; k < 6 && k < wlog_a.size(); k++)
            chk("gap.adr", wlog_a[k], 8'(k));

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        start();
        send(8'h10, 1'b0);
        send(8'h20, 1'b1);
        send(8'h30, 1'b0);
        tick();
        chk("cs.run", 8'(run_a), 8'h01);
        chk("cs.nwr", 8'(wlog_a.size()), 8'h02);
        chk("cs.count", cnt_a, 8'h02);
        do_reset();
        start();
        send(8'h10, 1'b0);
        send(8'h20, 1'b1);
        send(8'h31, 1'b0);
        tick();
        chk("cs.err", 8'(err_a), 8'h01);
        chk("cs.nwr_bad", 8'(wlog_a.size()), 8'h02);
`endif

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            res = ($urandom_range(0, 59) == 0);
            ld_start = ($urandom_range(0, 11) == 0);
            ld_valid = $urandom_range(0, 1) == 1;
            ld_last = ($urandom_range(0, 7) == 0);
            ld_data = 8'($urandom);
            tick();
        end
        res = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
